// File: rtl/note_seq.sv
// Melody sequencer: walks a note ROM one slot at a time, holding each note
// for TICK_DIV cycles, with pause, restart, loop and end-of-song signalling.
module note_seq #(
   parameter int TICK_DIV = 12500000,
   parameter int ADDR_W   = 8,
   parameter int SONG_LEN = 139
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              PLAY,
   input  logic              RESTART,
   input  logic              LOOP,
   output logic [ADDR_W-1:0] ROM_ADDR,
   input  logic [3:0]        ROM_DATA,
   output logic [3:0]        INX,
   output logic              NOTE_STB,
   output logic              BUSY,
   output logic              DONE
);

   localparam int                CNT_W     = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TICK_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_HOLD,
      S_FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [3:0]        note_q,  note_d;
   logic [3:0]        inx_q,   inx_d;
   logic              stb_q,   stb_d;
   logic              done_q,  done_d;

   // Next-state and registered-output logic; RESTART overrides everything.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      note_d  = note_q;
      inx_d   = inx_q;
      stb_d   = 1'b0;
      done_d  = 1'b0;
      if (RESTART) begin
         // INX keeps its current value so the restart has no extra gap
         state_d = S_FETCH;
         addr_d  = '0;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               addr_d = '0;
               inx_d  = 4'd0;
               if (PLAY) state_d = S_FETCH;
            end
            S_FETCH: begin
               // ROM sees addr_q this cycle; data arrives during LOAD
               state_d = S_LOAD;
            end
            S_LOAD: begin
               note_d  = ROM_DATA;
               inx_d   = ROM_DATA;
               stb_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_HOLD;
            end
            S_HOLD: begin
               if (PLAY) begin
                  inx_d = note_q;
                  if (cnt_q == CNT_LAST) begin
                     if (addr_q != ADDR_LAST) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                     end else if (LOOP) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                     end else begin
                        inx_d   = 4'd0;
                        done_d  = 1'b1;
                        state_d = S_FINISH;
                     end
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  // paused: mute output, freeze counter, keep note_q
                  inx_d = 4'd0;
               end
            end
            S_FINISH: begin
               if (!PLAY) begin
                  addr_d  = '0;
                  state_d = S_IDLE;
               end
            end
            default: begin
               addr_d  = '0;
               inx_d   = 4'd0;
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         note_q  <= 4'd0;
         inx_q   <= 4'd0;
         stb_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         note_q  <= note_d;
         inx_q   <= inx_d;
         stb_q   <= stb_d;
         done_q  <= done_d;
      end
   end

   assign ROM_ADDR = addr_q;
   assign INX      = inx_q;
   assign NOTE_STB = stb_q;
   assign DONE     = done_q;
   assign BUSY     = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                     (state_q == S_HOLD);

endmodule

// File: tb/tb_note_seq.sv
// Bench for note_seq: slot-schedule reference model with random pauses,
// plus directed restart and asynchronous reset scenarios.
module tb_note_seq;

   localparam int TD = 4;
   localparam int AW = 8;
   localparam int SL = 3;

   logic          CLK = 1'b0;
   logic          RST, PLAY, RESTART, LOOP;
   logic [AW-1:0] ROM_ADDR;
   logic [3:0]    ROM_DATA, INX;
   logic          NOTE_STB, BUSY, DONE;

   int errors = 0;
   int checks = 0;

   logic [3:0] rom [SL];

   // expected per-cycle outputs built by the schedule model
   logic [3:0]    e_inx  [256];
   logic [AW-1:0] e_addr [256];
   logic          e_stb  [256];
   logic          e_done [256];
   logic          e_busy [256];
   logic          e_play [256];
   logic          e_achk [256];

   note_seq #(.TICK_DIV(TD), .ADDR_W(AW), .SONG_LEN(SL)) dut (
      .CLK(CLK), .RST(RST), .PLAY(PLAY), .RESTART(RESTART), .LOOP(LOOP),
      .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA), .INX(INX),
      .NOTE_STB(NOTE_STB), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   // synchronous melody ROM, one cycle read latency
   always @(posedge CLK) ROM_DATA <= (ROM_ADDR < AW'(SL)) ? rom[ROM_ADDR[1:0]] : 4'hF;

   task automatic do_reset();
      RST = 1'b1; PLAY = 1'b0; RESTART = 1'b0; LOOP = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1; PLAY = 1'b0; RESTART = 1'b0; LOOP = 1'b0;
      @(negedge CLK);
      checks++; if (ROM_ADDR !== 8'd0) begin errors++; $display("FAIL reset addr got %0d want 0", ROM_ADDR); end
      checks++; if (INX !== 4'd0) begin errors++; $display("FAIL reset inx got %0d want 0", INX); end
      checks++; if (NOTE_STB !== 1'b0) begin errors++; $display("FAIL reset stb got %b want 0", NOTE_STB); end
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", BUSY); end
      checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset done got %b want 0", DONE); end
      RESTART = 1'b1;
      @(negedge CLK);
      checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_restart busy got %b want 0", BUSY); end
      RESTART = 1'b0;
      RST = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         checks++; if (BUSY !== 1'b0 || INX !== 4'd0) begin errors++; $display("FAIL idle busy/inx got %b/%0d want 0/0", BUSY, INX); end
      end
   endtask

   // mode 0: no pauses, 1: 10-cycle pause in note 0 HOLD, 2: random pauses
   task automatic run_song(input string name, input bit lp, input int nslots, input int mode);
      int s, e, t, pos, len, a;
      logic [3:0] n, prev;
      for (int i = 0; i < 256; i++) begin
         e_inx[i] = 4'd0; e_addr[i] = '0; e_stb[i] = 1'b0; e_done[i] = 1'b0;
         e_busy[i] = 1'b0; e_play[i] = 1'b1; e_achk[i] = 1'b1;
      end
      LOOP = lp;
      s = 3;
      prev = 4'd0;
      for (int k = 0; k < nslots; k++) begin
         a = k % SL;
         n = rom[a];
         for (int c = s - 2; c < s; c++) begin
            e_busy[c] = 1'b1; e_inx[c] = prev; e_addr[c] = AW'(a);
         end
         if (mode == 0) begin pos = 0; len = 0; end
         else if (mode == 1) begin pos = 2; len = (k == 0) ? 10 : 0; end
         else begin pos = $urandom_range(0, TD - 1); len = $urandom_range(0, 8); end
         for (int j = 0; j < TD + len; j++) begin
            e_busy[s+j] = 1'b1;
            e_addr[s+j] = AW'(a);
            e_inx[s+j]  = (j >= pos + 1 && j <= pos + len) ? 4'd0 : n;
            e_stb[s+j]  = (j == 0);
            e_play[s+j] = !(j >= pos && j < pos + len);
         end
         prev = n;
         s = s + TD + len + 2;
      end
      e = s - 2;
      if (!lp) begin
         e_done[e] = 1'b1;
         e_achk[e] = 1'b0;
         e_achk[e+1] = 1'b0;
         for (int c = e + 1; c < 256; c++) e_play[c] = 1'b0;
         t = e + 3;
      end else begin
         e_busy[e] = 1'b1; e_addr[e] = AW'(nslots % SL); e_inx[e] = prev;
         t = e + 1;
      end
      for (int c = 0; c < t; c++) begin
         @(negedge CLK);
         checks++; if (INX !== e_inx[c]) begin errors++; $display("FAIL %s inx c=%0d got %0d want %0d", name, c, INX, e_inx[c]); end
         checks++; if (NOTE_STB !== e_stb[c]) begin errors++; $display("FAIL %s stb c=%0d got %b want %b", name, c, NOTE_STB, e_stb[c]); end
         checks++; if (DONE !== e_done[c]) begin errors++; $display("FAIL %s done c=%0d got %b want %b", name, c, DONE, e_done[c]); end
         checks++; if (BUSY !== e_busy[c]) begin errors++; $display("FAIL %s busy c=%0d got %b want %b", name, c, BUSY, e_busy[c]); end
         if (e_achk[c]) begin
            checks++; if (ROM_ADDR !== e_addr[c]) begin errors++; $display("FAIL %s addr c=%0d got %0d want %0d", name, c, ROM_ADDR, e_addr[c]); end
         end
         PLAY = e_play[c];
      end
      do_reset();
   endtask

   // RESTART pulsed in cycle rc; no-pause schedule has note 12 HOLD at 15..18
   task automatic test_restart(input string name, input int rc);
      for (int c = 0; c < rc + 6; c++) begin
         @(negedge CLK);
         if (c == rc) begin
            checks++; if (ROM_ADDR !== 8'd2 || INX !== 4'd12 || BUSY !== 1'b1) begin errors++; $display("FAIL %s pre addr/inx/busy got %0d/%0d/%b want 2/12/1", name, ROM_ADDR, INX, BUSY); end
         end
         if (c == rc + 1) begin
            checks++; if (ROM_ADDR !== 8'd0 || BUSY !== 1'b1 || NOTE_STB !== 1'b0) begin errors++; $display("FAIL %s fetch addr/busy/stb got %0d/%b/%b want 0/1/0", name, ROM_ADDR, BUSY, NOTE_STB); end
         end
         if (c == rc + 2) begin
            checks++; if (NOTE_STB !== 1'b0 || BUSY !== 1'b1) begin errors++; $display("FAIL %s load stb/busy got %b/%b want 0/1", name, NOTE_STB, BUSY); end
         end
         if (c == rc + 3) begin
            checks++; if (NOTE_STB !== 1'b1 || INX !== 4'd5 || ROM_ADDR !== 8'd0) begin errors++; $display("FAIL %s note stb/inx/addr got %b/%0d/%0d want 1/5/0", name, NOTE_STB, INX, ROM_ADDR); end
         end
         if (c > rc) begin
            checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL %s done c=%0d got %b want 0", name, c, DONE); end
         end
         PLAY = 1'b1;
         RESTART = (c == rc);
      end
      RESTART = 1'b0;
      do_reset();
   endtask

   task automatic test_async_reset();
      for (int c = 0; c <= 8; c++) begin
         @(negedge CLK);
         PLAY = 1'b1;
      end
      // cycle 8 is the LOAD of entry 1
      checks++; if (ROM_ADDR !== 8'd1 || INX !== 4'd5 || BUSY !== 1'b1) begin errors++; $display("FAIL arst pre addr/inx/busy got %0d/%0d/%b want 1/5/1", ROM_ADDR, INX, BUSY); end
      #1 RST = 1'b1;
      #1;
      checks++; if (ROM_ADDR !== 8'd0 || INX !== 4'd0) begin errors++; $display("FAIL arst addr/inx got %0d/%0d want 0/0", ROM_ADDR, INX); end
      checks++; if (BUSY !== 1'b0 || NOTE_STB !== 1'b0 || DONE !== 1'b0) begin errors++; $display("FAIL arst busy/stb/done got %b/%b/%b want 0/0/0", BUSY, NOTE_STB, DONE); end
      RESTART = 1'b1;
      @(negedge CLK);
      checks++; if (BUSY !== 1'b0 || ROM_ADDR !== 8'd0) begin errors++; $display("FAIL arst_restart busy/addr got %b/%0d want 0/0", BUSY, ROM_ADDR); end
      RESTART = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      checks++; if (BUSY !== 1'b0 || INX !== 4'd0) begin errors++; $display("FAIL arst_idle busy/inx got %b/%0d want 0/0", BUSY, INX); end
      @(negedge CLK);
      checks++; if (BUSY !== 1'b1 || ROM_ADDR !== 8'd0 || NOTE_STB !== 1'b0) begin errors++; $display("FAIL arst_fetch busy/addr/stb got %b/%0d/%b want 1/0/0", BUSY, ROM_ADDR, NOTE_STB); end
      @(negedge CLK);
      @(negedge CLK);
      checks++; if (NOTE_STB !== 1'b1 || INX !== 4'd5) begin errors++; $display("FAIL arst_note stb/inx got %b/%0d want 1/5", NOTE_STB, INX); end
      do_reset();
   endtask

   initial begin
      rom[0] = 4'd5; rom[1] = 4'd0; rom[2] = 4'd12;
      test_reset();
      run_song("plain", 1'b0, 3, 0);
      run_song("pause", 1'b0, 3, 1);
      for (int r = 0; r < 3; r++) run_song("rand", 1'b0, 3, 2);
      run_song("loop", 1'b1, 7, 0);
      run_song("loop_rand", 1'b1, 8, 2);
      test_restart("restart_hold", 16);
      test_restart("restart_end", 18);
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/note_seq.md
NOTE_SEQ -- requirements
Module: note_seq

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12500000, CLK cycles per note slot (4 Hz at 50 MHz); legal values are 2 and above.
REQ-002 SHALL have parameter ADDR_W, default 8, melody ROM address width.
REQ-003 SHALL have parameter SONG_LEN, default 139, number of melody entries; legal values are 1 to 2^ADDR_W.
REQ-004 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port PLAY  input  1  level; 1 runs the song, 0 pauses it.
REQ-007 SHALL have port RESTART  input  1  one-cycle pulse; restarts the song from entry 0.
REQ-008 SHALL have port LOOP  input  1  level; 1 wraps the song to entry 0 after the last entry.
REQ-009 SHALL have port ROM_ADDR  output  ADDR_W  melody ROM address.
REQ-010 SHALL have port ROM_DATA  input  4  note index from the ROM, valid one cycle after ROM_ADDR is presented.
REQ-011 SHALL have port INX  output  4  note index to the frequency-code lookup; 0 means silence.
REQ-012 SHALL have port NOTE_STB  output  1  one-cycle pulse when a new note appears on INX.
REQ-013 SHALL have port BUSY  output  1  high while the song is in progress.
REQ-014 SHALL have port DONE  output  1  one-cycle pulse at the end of a non-looping song.

Function
REQ-015 SHALL implement the states IDLE, FETCH, LOAD, HOLD and FINISH.
REQ-016 IDLE SHALL hold ROM_ADDR=0 and INX=0, and SHALL move to FETCH on the first cycle with PLAY=1.
REQ-017 FETCH SHALL present ROM_ADDR for one cycle and then move to LOAD.
REQ-018 LOAD SHALL register ROM_DATA into the note register, assert NOTE_STB, clear the slot counter, and move to HOLD; the new INX value and NOTE_STB both become visible on the first HOLD cycle.
REQ-019 In HOLD the slot counter SHALL increment while PLAY=1.
REQ-020 In HOLD with PLAY=0 the slot counter SHALL freeze and INX SHALL read 0; the note register SHALL be retained, and INX SHALL return to it on the cycle after PLAY returns to 1.
REQ-021 HOLD SHALL last exactly TICK_DIV cycles with PLAY=1, so one note slot is TICK_DIV+2 cycles including FETCH and LOAD.
REQ-022 During FETCH and LOAD, INX SHALL keep the previous note so there is no audible gap between notes.
REQ-023 At the end of a slot, when ROM_ADDR < SONG_LEN-1, the block SHALL increment ROM_ADDR and move to FETCH.
REQ-024 At the end of a slot, when ROM_ADDR = SONG_LEN-1 and LOOP=1, the block SHALL set ROM_ADDR=0 and move to FETCH.
REQ-025 At the end of a slot, when ROM_ADDR = SONG_LEN-1 and LOOP=0, the block SHALL move to FINISH.
REQ-026 On entering FINISH the block SHALL set INX=0 and pulse DONE for one cycle.
REQ-027 FINISH SHALL move to IDLE when PLAY=0; it SHALL stay in FINISH while PLAY remains 1.
REQ-028 RESTART=1 in any state SHALL clear the slot counter, set ROM_ADDR=0 and move to FETCH.
REQ-029 RESTART SHALL take priority over the end-of-slot event and over PLAY=0; it has no effect while RST is asserted.
REQ-030 BUSY SHALL be 1 exactly in FETCH, LOAD and HOLD.
REQ-031 The slot counter SHALL be ceil(log2(TICK_DIV)) bits wide and SHALL never exceed TICK_DIV-1.
REQ-032 ROM_ADDR SHALL never exceed SONG_LEN-1; when SONG_LEN=1 and LOOP=1 the single entry SHALL repeat indefinitely.
REQ-033 Latency: a PLAY rise in IDLE at cycle n SHALL give FETCH at n+1, LOAD at n+2, and NOTE_STB with the new INX at n+3.

Reset
REQ-034 RST=1 SHALL immediately force state IDLE, ROM_ADDR=0, INX=0, slot counter=0, and NOTE_STB, BUSY, DONE all 0.
REQ-035 RST asserted mid-song SHALL abandon the song; after RST falls, playback SHALL start again from entry 0.

Verification (TICK_DIV=4, SONG_LEN=3, ROM = {5, 0, 12})
REQ-036 Bench SHALL cover: PLAY held at 1, LOOP=0 -> INX sequence 5, 0, 12, each with a NOTE_STB and 6 cycles apart, then DONE pulses once, INX=0 and BUSY=0.
REQ-037 Bench SHALL cover: LOOP=1 -> after 12 the addresses run 0, 1, 2, 0, 1, ... and DONE never pulses.
REQ-038 Bench SHALL cover: PLAY=0 for 10 cycles mid-HOLD of note 5 -> INX=0 and the counter frozen; after resume, INX=5 and the remaining slot cycles equal the count left at the pause.
REQ-039 Bench SHALL cover: RESTART during HOLD of note 12 -> ROM_ADDR=0, and NOTE_STB with INX=5 follows 3 cycles after the pulse.
REQ-040 Bench SHALL cover: RESTART on the same cycle as the end of the last slot with LOOP=0 -> no DONE, and the song restarts at entry 0.
REQ-041 Bench SHALL cover: RST asserted asynchronously between clock edges during LOAD -> all outputs read 0 before the next CLK edge, and the state is IDLE after release.
